// File: rtl/regfile_sb.sv
// Multi-bank register file with RAW scoreboard and sequenced clear; reads are combinational
// with write bypass, writes land next edge, no backpressure (clear masks all updates for DEPTH cycles).
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             read_a,
  input  logic [AW-1:0]    a_addr,
  output logic [WIDTH-1:0] a,
  output logic             a_busy,
  input  logic             read_b,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] b,
  output logic             b_busy,
  input  logic             write,
  input  logic [AW-1:0]    in_addr,
  input  logic [WIDTH-1:0] in,
  input  logic             reserve,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             clear,
  output logic             clearing
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_idx;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;

  logic w_idle;
  logic w_wr_ok;
  logic w_rsv_ok;
  logic w_byp_a;
  logic w_byp_b;

  assign w_idle   = (r_state == S_IDLE);
  assign w_wr_ok  = write && !(ZERO_REG != 0 && in_addr == '0);
  assign w_rsv_ok = reserve && !(ZERO_REG != 0 && rsv_addr == '0);
  assign w_byp_a  = write && (in_addr == a_addr);
  assign w_byp_b  = write && (in_addr == b_addr);
  assign clearing = (r_state == S_CLEAR);

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_pend  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
          end else begin
            if (w_wr_ok) begin
              r_mem[in_addr]  <= in;
              r_pend[in_addr] <= 1'b0;
            end
            // Reserve after write so a new producer in the same cycle keeps the reg pending.
            if (w_rsv_ok) r_pend[rsv_addr] <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_mem[r_idx]  <= '0;
          r_pend[r_idx] <= 1'b0;
          r_idx         <= r_idx + AW'(1);
          if (r_idx == AW'(DEPTH - 1)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    a      = '0;
    a_busy = 1'b0;
    if (!w_idle) begin
      a_busy = 1'b1;
    end else if (read_a) begin
      a_busy = r_pend[a_addr] && !w_byp_a;
      if (ZERO_REG != 0 && a_addr == '0) a = '0;
      else if (w_byp_a)                  a = in;
      else                               a = r_mem[a_addr];
    end
  end

  always_comb begin
    b      = '0;
    b_busy = 1'b0;
    if (!w_idle) begin
      b_busy = 1'b1;
    end else if (read_b) begin
      b_busy = r_pend[b_addr] && !w_byp_b;
      if (ZERO_REG != 0 && b_addr == '0) b = '0;
      else if (w_byp_b)                  b = in;
      else                               b = r_mem[b_addr];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one ZERO_REG=1 and one ZERO_REG=0 instance share stimulus,
// expected values go through a scoreboard queue and are compared at the negedge.
module tb_regfile_sb;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          m_clock = 1'b0;
  logic          p_reset;
  logic          read_a, read_b, write, reserve, clear;
  logic [AW-1:0] a_addr, b_addr, in_addr, rsv_addr;
  logic [W-1:0]  in;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          a_busy0, b_busy0, clearing0;
  logic          a_busy1, b_busy1, clearing1;

  regfile_sb #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) u_z (
    .m_clock(m_clock), .p_reset(p_reset),
    .read_a(read_a), .a_addr(a_addr), .a(a0), .a_busy(a_busy0),
    .read_b(read_b), .b_addr(b_addr), .b(b0), .b_busy(b_busy0),
    .write(write), .in_addr(in_addr), .in(in),
    .reserve(reserve), .rsv_addr(rsv_addr),
    .clear(clear), .clearing(clearing0)
  );

  regfile_sb #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0)) u_nz (
    .m_clock(m_clock), .p_reset(p_reset),
    .read_a(read_a), .a_addr(a_addr), .a(a1), .a_busy(a_busy1),
    .read_b(read_b), .b_addr(b_addr), .b(b1), .b_busy(b_busy1),
    .write(write), .in_addr(in_addr), .in(in),
    .reserve(reserve), .rsv_addr(rsv_addr),
    .clear(clear), .clearing(clearing1)
  );

  always #5 m_clock = ~m_clock;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } sb_t;

  sb_t sbq[$];
  int  total = 0;
  int  bad   = 0;

  task automatic push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    sb_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic idle();
    read_a = 1'b0; a_addr = '0;
    read_b = 1'b0; b_addr = '0;
    write = 1'b0; in_addr = '0; in = '0;
    reserve = 1'b0; rsv_addr = '0;
    clear = 1'b0;
  endtask

  // Inputs change just after the active edge; outputs are sampled at the following negedge.
  task automatic next();
    @(posedge m_clock);
    #1;
  endtask

  task automatic chk0(input string tag, input logic [31:0] ea, input logic eab,
                      input logic [31:0] eb, input logic ebb, input logic eclr);
    push({tag, ".a"}, ea);
    push({tag, ".a_busy"}, 32'(eab));
    push({tag, ".b"}, eb);
    push({tag, ".b_busy"}, 32'(ebb));
    push({tag, ".clearing"}, 32'(eclr));
    @(negedge m_clock);
    pop_cmp(a0);
    pop_cmp(32'(a_busy0));
    pop_cmp(b0);
    pop_cmp(32'(b_busy0));
    pop_cmp(32'(clearing0));
  endtask

  task automatic chk1(input string tag, input logic [31:0] ea, input logic eab);
    push({tag, ".nz_a"}, ea);
    push({tag, ".nz_a_busy"}, 32'(eab));
    pop_cmp(a1);
    pop_cmp(32'(a_busy1));
  endtask

  initial begin
    idle();
    p_reset = 1'b1;
    next();
    next();
    p_reset = 1'b0;

    // Reset state: every register reads zero and nothing pending.
    for (int i = 0; i < D; i++) begin
      next(); idle();
      read_a = 1'b1; a_addr = AW'(i);
      read_b = 1'b1; b_addr = AW'(D - 1 - i);
      chk0("rst_rd", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    end

    next(); idle();
    write = 1'b1; in_addr = 5'd5; in = 32'hDEADBEEF;
    next(); idle();
    read_a = 1'b1; a_addr = 5'd5;
    chk0("r5_rd", 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0);

    // Same-cycle bypass; port B disabled must stay zero.
    next(); idle();
    write = 1'b1; in_addr = 5'd7; in = 32'h12345678;
    read_a = 1'b1; a_addr = 5'd7;
    read_b = 1'b0; b_addr = 5'd7;
    chk0("byp_r7", 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0);
    next(); idle();
    read_a = 1'b1; a_addr = 5'd7;
    read_b = 1'b1; b_addr = 5'd7;
    chk0("r7_st", 32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0);

    // Register 0: hardwired in u_z, ordinary in u_nz.
    next(); idle();
    write = 1'b1; in_addr = 5'd0; in = 32'hFFFFFFFF;
    reserve = 1'b1; rsv_addr = 5'd0;
    read_a = 1'b1; a_addr = 5'd0;
    chk0("z_byp", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk1("z_byp", 32'hFFFFFFFF, 1'b0);
    next(); idle();
    read_a = 1'b1; a_addr = 5'd0;
    chk0("z_rd", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk1("z_rd", 32'hFFFFFFFF, 1'b1);

    // Scoreboard on r3: reserve, pending, then writeback.
    next(); idle();
    reserve = 1'b1; rsv_addr = 5'd3;
    read_a = 1'b1; a_addr = 5'd3;
    chk0("rsv_c1", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    next(); idle();
    read_a = 1'b1; a_addr = 5'd3;
    chk0("rsv_c2", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    next(); idle();
    read_a = 1'b1; a_addr = 5'd3;
    chk0("rsv_c3", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    next(); idle();
    write = 1'b1; in_addr = 5'd3; in = 32'h55;
    read_a = 1'b1; a_addr = 5'd3;
    chk0("wb_c4", 32'h55, 1'b0, 32'h0, 1'b0, 1'b0);
    next(); idle();
    read_a = 1'b1; a_addr = 5'd3;
    chk0("wb_c5", 32'h55, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reserve and write the same reg: data lands, pending stays set.
    next(); idle();
    write = 1'b1; in_addr = 5'd9; in = 32'hA5A5A5A5;
    reserve = 1'b1; rsv_addr = 5'd9;
    read_b = 1'b1; b_addr = 5'd9;
    chk0("rw9_c0", 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);
    next(); idle();
    read_b = 1'b1; b_addr = 5'd9;
    read_a = 1'b0; a_addr = 5'd9;
    chk0("rw9_c1", 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0);

    // Fill everything, then run a full clear with interference.
    for (int i = 0; i < D; i++) begin
      next(); idle();
      write = 1'b1; in_addr = AW'(i); in = 32'hC0DE0000 | 32'(i);
    end
    next(); idle();
    reserve = 1'b1; rsv_addr = 5'd4;
    next(); idle();
    read_a = 1'b1; a_addr = 5'd31;
    read_b = 1'b1; b_addr = 5'd4;
    chk0("fill", 32'hC0DE001F, 1'b0, 32'hC0DE0004, 1'b1, 1'b0);

    next(); idle();
    clear = 1'b1;
    write = 1'b1; in_addr = 5'd2; in = 32'hBAD0BAD0;
    reserve = 1'b1; rsv_addr = 5'd2;
    read_a = 1'b1; a_addr = 5'd31;
    chk0("clr_t", 32'hC0DE001F, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= D; k++) begin
      next(); idle();
      read_a = 1'(k % 2); a_addr = AW'(k - 1);
      read_b = 1'b1; b_addr = AW'(D - k);
      if (k == 5) clear = 1'b1;
      if (k == 10) begin
        write = 1'b1; in_addr = 5'd30; in = 32'h0BADF00D;
      end
      if (k == D) begin
        write = 1'b1; in_addr = 5'd1; in = 32'hFFFFFFFF;
        reserve = 1'b1; rsv_addr = 5'd6;
      end
      chk0("clr_run", 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    end
    for (int i = 0; i < D; i++) begin
      next(); idle();
      read_a = 1'b1; a_addr = AW'(i);
      read_b = 1'b1; b_addr = AW'(i);
      chk0("post_clr", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk1("post_clr", 32'h0, 1'b0);
    end

    // Reset in the middle of a clear aborts it.
    next(); idle();
    write = 1'b1; in_addr = 5'd20; in = 32'h88;
    next(); idle();
    reserve = 1'b1; rsv_addr = 5'd21;
    next(); idle();
    clear = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      next(); idle();
      if (k == 10) p_reset = 1'b1;
      read_a = 1'b1; a_addr = 5'd20;
      chk0("rc_run", 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    end
    next(); idle();
    p_reset = 1'b0;
    read_a = 1'b1; a_addr = 5'd20;
    read_b = 1'b1; b_addr = 5'd21;
    chk0("rc_after", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    next(); idle();
    clear = 1'b1;
    chk0("nc_t", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= D; k++) begin
      next(); idle();
      chk0("nc_run", 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    end
    next(); idle();
    chk0("nc_end", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    next();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-bank register file with a per-register scoreboard and a sequenced clear, for the pipelined datapath. It provides two asynchronous read ports and one write port, with an optional hardwired-zero register 0 and same-cycle write-to-read bypass. It also tracks per-register pending-write bits so the issue stage can detect RAW hazards. It replaces the fixed 32x32 file used by the single-cycle core.

## Interface
- WIDTH, 32: data width in bits.
- DEPTH, 32: number of registers; power of two, 2..256; AW = log2(DEPTH).
- ZERO_REG, 1: when 1, register 0 reads as zero, and writes/reserves to it are discarded.

- m_clock  in  1  clock; all state updates on rising edge.
- p_reset  in  1  synchronous, active-high reset.
- read_a  in  1  read port A enable.
- a_addr  in  AW  port A address.
- a  out  WIDTH  port A data.
- a_busy  out  1  port A operand pending (hazard).
- read_b / b_addr / b / b_busy: port B, identical to port A.
- write  in  1  write enable (writeback).
- in_addr  in  AW  write address.
- in  in  WIDTH  write data.
- reserve  in  1  mark a register pending (issue of a producer).
- rsv_addr  in  AW  register to reserve.
- clear  in  1  request a full clear; one-cycle pulse sufficient.
- clearing  out  1  clear sequence in progress.

## Operation
- Storage: DEPTH x WIDTH flops plus pending[DEPTH]. Under ZERO_REG, entry 0 and pending[0] are held at 0.
- Read (combinational):
  - If read_x=0, the output is 0.
  - If ZERO_REG and addr=0, the output is 0.
  - Else if write=1 and in_addr=addr (and the target is not a discarded reg 0), the output is `in` (bypass).
  - Else the output is the stored entry.
- Busy: x_busy = read_x & pending[addr] & ~(write & in_addr==addr).
  - During clearing, a_busy=b_busy=1 and a=b=0 regardless of the inputs.
- Write: when write=1 in IDLE, entry[in_addr] <= in and pending[in_addr] <= 0.
- Reserve: when reserve=1 in IDLE, pending[rsv_addr] <= 1.
  - If reserve and write target the same register in the same cycle, the data is written and pending ends at 1 (the new producer wins).
- Clear FSM, states IDLE and CLEAR, index register idx[AW-1:0]:
  - IDLE and clear=1: go to CLEAR with idx=0. Any write/reserve in the same cycle is dropped.
  - CLEAR: entry[idx] <= 0 and pending[idx] <= 0 each cycle, then idx++. When idx=DEPTH-1, return to IDLE.
  - In CLEAR, write, reserve and clear inputs are ignored; clear does not restart the sequence.
- Reset:
  - All entries and pending bits go to 0, state IDLE, idx 0.
  - Outputs after reset: a=b=0, a_busy=b_busy=0, clearing=0.
  - Reset mid-clear aborts the sequence; reset has the same effect regardless of state.

## Timing
- Read latency 0: combinational from address/enable.
- Write is visible in the same cycle through the bypass, and from storage from the next cycle on.
- Reserve is visible on x_busy in the cycle after it is asserted.
- Write clears busy combinationally in the same cycle (bypass), and in storage from the next cycle.
- A clear accepted in cycle t gives clearing=1 in cycles t+1..t+DEPTH. Entry k is zeroed at the end of cycle t+1+k. clearing=0 and normal operation resume in cycle t+DEPTH+1.
- No combinational path from clear to clearing. clearing is a registered state decode.
- Address arithmetic: idx wraps modulo DEPTH. There is no out-of-range address because all addresses are AW bits.

## Test plan
- Reset, then read_a/read_b of every register: a=b=0 and busy=0. Write 0xDEADBEEF to r5, read r5 next cycle: a=0xDEADBEEF.
- Bypass: write r7=0x12345678 and read_a r7 in the same cycle: a=0x12345678 in that cycle. Read_b r7 with read_b=0: b=0.
- ZERO_REG=1: write r0=0xFFFFFFFF and reserve r0, then read r0: a=0 and a_busy=0. With ZERO_REG=0 the same write reads back 0xFFFFFFFF.
- Scoreboard:
  - Reserve r3 at cycle 1: a_busy=1 from cycle 2.
  - Write r3=0x55 at cycle 4: a_busy=0 and a=0x55 in cycle 4.
  - Reserve and write r9 in the same cycle: b_busy=1 next cycle and the data is updated.
- Clear with DEPTH=32: fill all registers, pulse clear at t. Expect:
  - clearing high for exactly 32 cycles.
  - Writes and reserves issued during clearing have no effect.
  - A second clear pulse mid-sequence does not extend clearing.
  - All entries read 0 at t+33.
- Reset mid-clear at cycle t+10: clearing=0 the next cycle, all entries 0, and a new clear is accepted normally.
